// File: rtl/mcb_port_arbiter.sv
// Shares one Spartan-6 MCB user port between two burst requesters: one grant at a time,
// write bursts fill the FIFO then issue the command, read bursts issue the command then drain.
module mcb_port_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int TIMEOUT_W      = 16
) (
  input  logic        ifclk,
  input  logic        resetb,
  input  logic        rq0_req,
  input  logic        rq0_write,
  input  logic [29:0] rq0_addr,
  input  logic [5:0]  rq0_bl,
  input  logic [31:0] rq0_wdata,
  input  logic        rq0_wvalid,
  output logic        rq0_wready,
  output logic [31:0] rq0_rdata,
  output logic        rq0_rvalid,
  output logic        rq0_grant,
  output logic        rq0_done,
  output logic        rq0_err,
  input  logic        rq1_req,
  input  logic        rq1_write,
  input  logic [29:0] rq1_addr,
  input  logic [5:0]  rq1_bl,
  input  logic [31:0] rq1_wdata,
  input  logic        rq1_wvalid,
  output logic        rq1_wready,
  output logic [31:0] rq1_rdata,
  output logic        rq1_rvalid,
  output logic        rq1_grant,
  output logic        rq1_done,
  output logic        rq1_err,
  output logic        p_cmd_en,
  output logic [2:0]  p_cmd_instr,
  output logic [5:0]  p_cmd_bl,
  output logic [29:0] p_cmd_byte_addr,
  input  logic        p_cmd_full,
  output logic        p_wr_en,
  output logic [3:0]  p_wr_mask,
  output logic [31:0] p_wr_data,
  input  logic        p_wr_full,
  input  logic        p_wr_underrun,
  output logic        p_rd_en,
  input  logic [31:0] p_rd_data,
  input  logic        p_rd_empty,
  input  logic        p_rd_error
);

  // state  | meaning
  // IDLE   | no owner; arbitrate pending requests
  // WFILL  | owner streams bl+1 words into the MCB write FIFO
  // WCMD   | issue the write command
  // RCMD   | issue the read command
  // RDRAIN | forward bl+1 read words to the owner, watchdog armed
  // DONE   | one-cycle done pulse, owner still granted
  typedef enum logic [2:0] {
    S_IDLE, S_WFILL, S_WCMD, S_RCMD, S_RDRAIN, S_DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WDOG_ONE = TIMEOUT_W'(1);

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 write_q, write_d;
  logic [27:0]          addr_q, addr_d;
  logic [5:0]           bl_q, bl_d;
  logic [6:0]           cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [1:0]           err_q, err_d;
  logic                 win;

  logic in_wfill, in_wcmd, in_rcmd, in_rdrain, in_done, in_cmd, busy;
  logic sel_wvalid, wr_acc, rd_acc, cmd_fire, last_word;
  logic unused_addr_lsbs;

  assign in_wfill  = (state_q == S_WFILL);
  assign in_wcmd   = (state_q == S_WCMD);
  assign in_rcmd   = (state_q == S_RCMD);
  assign in_rdrain = (state_q == S_RDRAIN);
  assign in_done   = (state_q == S_DONE);
  assign in_cmd    = in_wcmd | in_rcmd;
  assign busy      = (state_q != S_IDLE);

  assign sel_wvalid = owner_q ? rq1_wvalid : rq0_wvalid;
  assign wr_acc     = in_wfill & sel_wvalid & ~p_wr_full;
  assign rd_acc     = in_rdrain & ~p_rd_empty;
  assign cmd_fire   = in_cmd & ~p_cmd_full;
  // 7-bit count against bl so a 64-word burst terminates without wrapping
  assign last_word  = (cnt_q == {1'b0, bl_q});

  assign unused_addr_lsbs = ^{rq0_addr[1:0], rq1_addr[1:0]};

  assign rq0_grant  = busy & ~owner_q;
  assign rq1_grant  = busy & owner_q;
  assign rq0_wready = in_wfill & ~owner_q & ~p_wr_full;
  assign rq1_wready = in_wfill & owner_q & ~p_wr_full;
  assign rq0_rvalid = rd_acc & ~owner_q;
  assign rq1_rvalid = rd_acc & owner_q;
  assign rq0_rdata  = (in_rdrain & ~owner_q) ? p_rd_data : '0;
  assign rq1_rdata  = (in_rdrain & owner_q) ? p_rd_data : '0;
  assign rq0_done   = in_done & ~owner_q;
  assign rq1_done   = in_done & owner_q;
  assign rq0_err    = err_q[0];
  assign rq1_err    = err_q[1];

  assign p_cmd_en        = cmd_fire;
  assign p_cmd_instr     = {2'b00, in_rcmd};
  assign p_cmd_bl        = in_cmd ? bl_q : '0;
  assign p_cmd_byte_addr = in_cmd ? {addr_q, 2'b00} : '0;
  assign p_wr_en         = wr_acc;
  assign p_wr_mask       = 4'b0000;
  assign p_wr_data       = in_wfill ? (owner_q ? rq1_wdata : rq0_wdata) : '0;
  assign p_rd_en         = rd_acc;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    write_d = write_q;
    addr_d  = addr_q;
    bl_d    = bl_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rq0_req | rq1_req) begin
          if (rq0_req & rq1_req) win = FIXED_PRIORITY ? 1'b0 : ~last_q;
          else                   win = rq1_req;
          owner_d    = win;
          last_d     = win;
          write_d    = win ? rq1_write : rq0_write;
          addr_d     = win ? rq1_addr[29:2] : rq0_addr[29:2];
          bl_d       = win ? rq1_bl : rq0_bl;
          cnt_d      = '0;
          wdog_d     = '0;
          err_d[win] = 1'b0;
          state_d    = write_d ? S_WFILL : S_RCMD;
        end
      end
      S_WFILL: begin
        if (wr_acc) begin
          cnt_d = cnt_q + 7'd1;
          if (last_word) state_d = S_WCMD;
        end
      end
      S_WCMD:  if (cmd_fire) state_d = S_DONE;
      S_RCMD:  if (cmd_fire) state_d = S_RDRAIN;
      S_RDRAIN: begin
        if (rd_acc) begin
          cnt_d  = cnt_q + 7'd1;
          wdog_d = '0;
          if (last_word) state_d = S_DONE;
        end else if (&wdog_q) begin
          err_d[owner_q] = 1'b1;
          state_d        = S_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (busy & (p_wr_underrun | p_rd_error)) err_d[owner_q] = 1'b1;
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      bl_q    <= '0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      bl_q    <= bl_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Bench for mcb_port_arbiter: a table of directed rounds, a reset-in-drain sequence and
// randomized rounds checked against a transaction-level model of grant order, bursts and errors.
module tb_mcb_port_arbiter;
  localparam int TW       = 4;
  localparam int M_CLEAN  = 0;
  localparam int M_NOISY  = 1;
  localparam int M_STUCK  = 2;
  localparam int M_STALL  = 3;
  localparam int M_TOGGLE = 4;

  logic ifclk = 1'b0;
  logic resetb;
  logic rq0_req, rq0_write, rq0_wvalid, rq0_wready, rq0_rvalid, rq0_grant, rq0_done, rq0_err;
  logic rq1_req, rq1_write, rq1_wvalid, rq1_wready, rq1_rvalid, rq1_grant, rq1_done, rq1_err;
  logic [29:0] rq0_addr, rq1_addr;
  logic [5:0]  rq0_bl, rq1_bl;
  logic [31:0] rq0_wdata, rq1_wdata, rq0_rdata, rq1_rdata;
  logic        p_cmd_en, p_cmd_full, p_wr_en, p_wr_full, p_wr_underrun, p_rd_en, p_rd_empty, p_rd_error;
  logic [2:0]  p_cmd_instr;
  logic [5:0]  p_cmd_bl;
  logic [29:0] p_cmd_byte_addr;
  logic [3:0]  p_wr_mask;
  logic [31:0] p_wr_data, p_rd_data;

  int checks = 0;
  int failures = 0;
  bit m_last;
  bit m_err [2];

  always #5 ifclk = ~ifclk;

  mcb_port_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_W(TW)) dut (
    .ifclk(ifclk), .resetb(resetb),
    .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_bl(rq0_bl),
    .rq0_wdata(rq0_wdata), .rq0_wvalid(rq0_wvalid), .rq0_wready(rq0_wready),
    .rq0_rdata(rq0_rdata), .rq0_rvalid(rq0_rvalid), .rq0_grant(rq0_grant),
    .rq0_done(rq0_done), .rq0_err(rq0_err),
    .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_bl(rq1_bl),
    .rq1_wdata(rq1_wdata), .rq1_wvalid(rq1_wvalid), .rq1_wready(rq1_wready),
    .rq1_rdata(rq1_rdata), .rq1_rvalid(rq1_rvalid), .rq1_grant(rq1_grant),
    .rq1_done(rq1_done), .rq1_err(rq1_err),
    .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
    .p_wr_en(p_wr_en), .p_wr_mask(p_wr_mask), .p_wr_data(p_wr_data), .p_wr_full(p_wr_full),
    .p_wr_underrun(p_wr_underrun), .p_rd_en(p_rd_en), .p_rd_data(p_rd_data),
    .p_rd_empty(p_rd_empty), .p_rd_error(p_rd_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit any_out();
    return |{rq0_wready, rq0_rdata, rq0_rvalid, rq0_grant, rq0_done, rq0_err,
             rq1_wready, rq1_rdata, rq1_rvalid, rq1_grant, rq1_done, rq1_err,
             p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
             p_wr_en, p_wr_mask, p_wr_data, p_rd_en};
  endfunction

  function automatic logic grant_of(input int n); return n ? rq1_grant : rq0_grant; endfunction
  function automatic logic wrdy_of(input int n);  return n ? rq1_wready : rq0_wready; endfunction
  function automatic logic rv_of(input int n);    return n ? rq1_rvalid : rq0_rvalid; endfunction
  function automatic logic done_of(input int n);  return n ? rq1_done : rq0_done; endfunction
  function automatic logic [31:0] rd_of(input int n); return n ? rq1_rdata : rq0_rdata; endfunction

  task automatic drive_rq(input int n, input logic req, input logic wr, input logic [29:0] a,
                          input logic [5:0] bl);
    if (n == 0) begin rq0_req = req; rq0_write = wr; rq0_addr = a; rq0_bl = bl; end
    else        begin rq1_req = req; rq1_write = wr; rq1_addr = a; rq1_bl = bl; end
  endtask

  task automatic set_w(input int n, input logic v, input logic [31:0] d);
    if (n == 0) begin rq0_wvalid = v; rq0_wdata = d; end
    else        begin rq1_wvalid = v; rq1_wdata = d; end
  endtask

  task automatic quiet_env();
    p_cmd_full = 1'b0; p_wr_full = 1'b0; p_rd_empty = 1'b1; p_rd_data = '0;
    p_wr_underrun = 1'b0; p_rd_error = 1'b0;
    set_w(0, 1'b0, '0); set_w(1, 1'b0, '0);
  endtask

  // Runs one granted burst for requester o (its req already high) and checks it end to end.
  task automatic run_txn(input int o, input bit wr, input logic [29:0] addr, input logic [5:0] bl,
                         input int mode);
    logic [31:0] wd [64];
    int cyc, gcyc, ccyc, dcyc, gown, words, cmds, viol, dmis, empt, stall;
    logic [2:0] c_instr; logic [5:0] c_bl; logic [29:0] c_addr;
    logic wv_o, inj;
    cyc = 0; gcyc = -1; ccyc = -1; dcyc = -1; gown = -1; words = 0; cmds = 0;
    viol = 0; dmis = 0; empt = 0; stall = 5;
    c_instr = '0; c_bl = '0; c_addr = '0;
    foreach (wd[i]) wd[i] = $urandom;
    while (dcyc < 0 && cyc < 800) begin
      @(negedge ifclk);
      cyc++;
      if (gcyc < 0 && (rq0_grant || rq1_grant)) begin
        gcyc = cyc;
        gown = rq1_grant ? 1 : 0;
        m_err[o] = 1'b0;
        drive_rq(o, (mode == M_NOISY) ? 1'($urandom_range(0, 1)) : 1'b1, ~wr,
                 30'($urandom), 6'($urandom));
      end
      p_wr_full  = (mode == M_NOISY) ? ($urandom_range(0, 2) == 0)
                                     : (mode == M_STALL && words >= 2 && stall > 0);
      if (mode == M_STALL && p_wr_full) stall--;
      p_cmd_full = (mode == M_NOISY) ? ($urandom_range(0, 2) == 0) : 1'b0;
      case (mode)
        M_STUCK:  p_rd_empty = 1'b1;
        M_NOISY:  p_rd_empty = (empt >= 6) ? 1'b0 : 1'($urandom_range(0, 1));
        M_TOGGLE: p_rd_empty = (cyc % 2 == 1);
        default:  p_rd_empty = 1'b0;
      endcase
      empt = p_rd_empty ? empt + 1 : 0;
      p_rd_data = $urandom;
      wv_o = (mode == M_NOISY) ? 1'($urandom_range(0, 1)) : 1'b1;
      set_w(o, wv_o, wd[words % 64]);
      set_w(1 - o, 1'($urandom_range(0, 1)), $urandom);
      inj = (mode == M_NOISY) && grant_of(o) && ($urandom_range(0, 29) == 0);
      p_wr_underrun = inj && $urandom_range(0, 1);
      p_rd_error    = inj && !p_wr_underrun;
      if (inj) m_err[o] = 1'b1;
      #1;
      if (p_wr_en) begin
        if (!wr || cmds != 0 || !wv_o || p_wr_full) viol++;
        if (p_wr_data !== wd[words % 64]) dmis++;
        words++;
      end
      if (rv_of(o)) begin
        if (wr || cmds == 0 || p_rd_empty || !p_rd_en) viol++;
        if (rd_of(o) !== p_rd_data) dmis++;
        words++;
      end
      if (p_rd_en && p_rd_empty) viol++;
      if (wrdy_of(o) && p_wr_full) viol++;
      if (p_cmd_en) begin
        cmds++; ccyc = cyc;
        c_instr = p_cmd_instr; c_bl = p_cmd_bl; c_addr = p_cmd_byte_addr;
      end
      if (grant_of(1 - o) || wrdy_of(1 - o) || rv_of(1 - o) || done_of(1 - o) || p_wr_mask != 0)
        viol++;
      if (done_of(o)) begin
        dcyc = cyc;
        if (!grant_of(o)) viol++;
        if (o == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
      end
    end
    chk($sformatf("done_seen_rq%0d", o), dcyc >= 0, 1);
    chk("grant_owner", gown, o);
    chk("grant_latency", gcyc, 1);
    chk("burst_words", words, (mode == M_STUCK) ? 0 : int'(bl) + 1);
    chk("burst_data", dmis, 0);
    chk("cmd_count", cmds, 1);
    chk("cmd_instr", c_instr, wr ? 3'b000 : 3'b001);
    chk("cmd_addr", c_addr, {addr[29:2], 2'b00});
    chk("cmd_bl", c_bl, bl);
    chk("protocol", viol, 0);
    if (mode == M_CLEAN || mode == M_STALL) begin
      chk("cmd_timing", ccyc - gcyc, wr ? int'(bl) + 1 + ((mode == M_STALL) ? 5 : 0) : 0);
      chk("done_timing", dcyc - ccyc, wr ? 1 : int'(bl) + 2);
    end
    if (mode == M_STUCK) begin
      chk("wdog_window", (dcyc - ccyc >= 15) && (dcyc - ccyc <= 18), 1);
      m_err[o] = 1'b1;
    end
    @(negedge ifclk);
    quiet_env();
    #1;
    chk("idle_gap", {rq0_grant, rq1_grant, rq0_done, rq1_done}, 0);
    chk("err_rq0", rq0_err, m_err[0]);
    chk("err_rq1", rq1_err, m_err[1]);
    m_last = (o != 0);
  endtask

  task automatic run_round(input bit w0, input bit w1, input bit wr0, input bit wr1,
                           input logic [29:0] a0, input logic [29:0] a1,
                           input logic [5:0] b0, input logic [5:0] b1,
                           input int mode, input int first);
    if (w0) drive_rq(0, 1'b1, wr0, a0, b0);
    if (w1) drive_rq(1, 1'b1, wr1, a1, b1);
    if (first == 0) begin
      run_txn(0, wr0, a0, b0, mode);
      if (w1) run_txn(1, wr1, a1, b1, mode);
    end else begin
      run_txn(1, wr1, a1, b1, mode);
      if (w0) run_txn(0, wr0, a0, b0, mode);
    end
  endtask

  typedef struct {
    bit w0; bit w1; bit wr0; bit wr1;
    logic [29:0] a0; logic [29:0] a1;
    logic [5:0] b0; logic [5:0] b1;
    int mode; int first;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int rv;
    tbl[0]  = '{1, 1, 1, 0, 30'h100,     30'h2004,    6'd3,  6'd2,  M_CLEAN,  0};
    tbl[1]  = '{1, 1, 0, 1, 30'h333,     30'h1001,    6'd4,  6'd1,  M_CLEAN,  0};
    tbl[2]  = '{0, 1, 0, 0, 30'h0,       30'h3ff_fff, 6'd0,  6'd7,  M_TOGGLE, 1};
    tbl[3]  = '{1, 0, 1, 0, 30'h40,      30'h0,       6'd5,  6'd0,  M_STALL,  0};
    tbl[4]  = '{1, 1, 1, 1, 30'h1234,    30'h5678,    6'd2,  6'd4,  M_CLEAN,  1};
    tbl[5]  = '{1, 1, 0, 0, 30'h2a_aaab, 30'h15_5555, 6'd1,  6'd3,  M_CLEAN,  1};
    tbl[6]  = '{1, 0, 0, 0, 30'h3fff_fffc, 30'h0,     6'd63, 6'd0,  M_CLEAN,  0};
    tbl[7]  = '{0, 1, 0, 1, 30'h0,       30'h800,     6'd0,  6'd63, M_CLEAN,  1};
    tbl[8]  = '{1, 0, 1, 0, 30'h7,       30'h0,       6'd0,  6'd0,  M_CLEAN,  0};
    tbl[9]  = '{0, 1, 0, 0, 30'h0,       30'h90,      6'd0,  6'd5,  M_STUCK,  1};
    tbl[10] = '{1, 0, 1, 0, 30'h44,      30'h0,       6'd1,  6'd0,  M_CLEAN,  0};
    tbl[11] = '{0, 1, 0, 1, 30'h0,       30'h88,      6'd0,  6'd2,  M_CLEAN,  1};

    resetb = 1'b0;
    drive_rq(0, 1'b0, 1'b0, '0, '0);
    drive_rq(1, 1'b0, 1'b0, '0, '0);
    quiet_env();
    m_last = 1'b1; m_err[0] = 1'b0; m_err[1] = 1'b0;
    repeat (2) @(negedge ifclk);
    #1;
    chk("reset_outputs", any_out(), 0);
    resetb = 1'b1;
    @(negedge ifclk);
    #1;
    chk("idle_after_reset", any_out(), 0);

    foreach (tbl[i])
      run_round(tbl[i].w0, tbl[i].w1, tbl[i].wr0, tbl[i].wr1, tbl[i].a0, tbl[i].a1,
                tbl[i].b0, tbl[i].b1, tbl[i].mode, tbl[i].first);

    // reset asserted between edges while rq1 is mid-drain
    drive_rq(1, 1'b1, 1'b0, 30'h777, 6'd20);
    p_rd_empty = 1'b0;
    rv = 0;
    for (int c = 0; c < 30 && rv < 3; c++) begin
      @(negedge ifclk);
      p_rd_data = $urandom;
      #1;
      if (rq1_rvalid) rv++;
    end
    chk("drain_started", rv, 3);
    #2;
    resetb = 1'b0;
    #1;
    chk("reset_async_outputs", any_out(), 0);
    rq1_req = 1'b0;
    quiet_env();
    m_last = 1'b1; m_err[0] = 1'b0; m_err[1] = 1'b0;
    @(negedge ifclk);
    #1;
    chk("reset_held_outputs", any_out(), 0);
    @(negedge ifclk);
    resetb = 1'b1;
    #1;
    run_round(1, 1, 1, 0, 30'h500, 30'h604, 6'd2, 6'd3, M_CLEAN, 0);

    for (int r = 0; r < 30; r++) begin
      bit w0, w1, wr0, wr1;
      logic [5:0] b0, b1;
      int first;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      if (!w0 && !w1) begin
        if ($urandom_range(0, 1) == 1) w0 = 1'b1; else w1 = 1'b1;
      end
      wr0 = 1'($urandom_range(0, 1));
      wr1 = 1'($urandom_range(0, 1));
      b0 = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 12));
      b1 = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 12));
      first = (w0 && w1) ? (m_last ? 0 : 1) : (w1 ? 1 : 0);
      run_round(w0, w1, wr0, wr1, 30'($urandom), 30'($urandom), b0, b1, M_NOISY, first);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
